axi_ad9364_dac_tpg: RTL and testbench

// Parametrised DAC test-pattern generator driving the dac_* sample interface of the AD9364 digital interface.

---
 rtl/axi_ad9364_dac_tpg.sv | 204 ++++++++++++++++++++
 tb/tb_axi_ad9364_dac_tpg.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ad9364_dac_tpg.sv
// DAC test-pattern generator for the AD9364 dac_* interface: zero, table, ramp and PRBS15 sources.
// One registered stage (valid and data on the same edge); no backpressure, pacing set by rate_div.
module axi_ad9364_dac_tpg #(
    parameter int          DATA_WIDTH    = 12,
    parameter int          NUM_CHANNELS  = 2,
    parameter int          PATTERN_DEPTH = 4,
    parameter logic [11:0] INIT_I0       = 12'o2064,
    parameter logic [11:0] INIT_Q0       = 12'o1753,
    parameter logic [11:0] INIT_I1       = 12'o4402,
    parameter logic [11:0] INIT_Q1       = 12'o1337,
    localparam int         AW            = $clog2(PATTERN_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic                    r1_mode,
    input  logic [3:0]              rate_div,
    input  logic [AW:0]             pat_len,
    input  logic                    pat_wr,
    input  logic [AW-1:0]           pat_addr,
    input  logic [2*DATA_WIDTH-1:0] pat_wdata,
    output logic                    dac_valid,
    output logic [DATA_WIDTH-1:0]   dac_data_i1,
    output logic [DATA_WIDTH-1:0]   dac_data_q1,
    output logic [DATA_WIDTH-1:0]   dac_data_i2,
    output logic [DATA_WIDTH-1:0]   dac_data_q2,
    output logic                    dac_r1_mode,
    output logic                    pat_wrap,
    output logic [31:0]             sample_count
);

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_TABLE = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_PRBS  = 2'd3
    } mode_e;

    localparam logic [DATA_WIDTH-1:0] L_I0      = DATA_WIDTH'(INIT_I0);
    localparam logic [DATA_WIDTH-1:0] L_Q0      = DATA_WIDTH'(INIT_Q0);
    localparam logic [DATA_WIDTH-1:0] L_I1      = DATA_WIDTH'(INIT_I1);
    localparam logic [DATA_WIDTH-1:0] L_Q1      = DATA_WIDTH'(INIT_Q1);
    localparam logic [14:0]           LFSR_SEED = 15'h7FFF;

    logic [2*DATA_WIDTH-1:0] r_tab [PATTERN_DEPTH];

    logic                  r_en_d;
    logic                  r_run;
    mode_e                 r_cfg_mode;
    logic                  r_cfg_r1;
    logic [3:0]            r_cfg_rate;
    logic [AW-1:0]         r_last_idx;
    logic [3:0]            r_rate_cnt;
    logic [AW-1:0]         r_index;
    logic [DATA_WIDTH-1:0] r_ramp;
    logic [14:0]           r_lfsr;
    logic                  r_valid;
    logic                  r_wrap;
    logic [DATA_WIDTH-1:0] r_i1;
    logic [DATA_WIDTH-1:0] r_q1;
    logic [DATA_WIDTH-1:0] r_i2;
    logic [DATA_WIDTH-1:0] r_q2;
    logic [31:0]           r_count;

    logic                  w_start;
    logic                  w_tick;
    logic                  w_two_ch;
    logic                  w_wrap;
    logic [AW-1:0]         w_len_last;
    logic [14:0]           w_lfsr_step;
    logic [DATA_WIDTH-1:0] w_i1;
    logic [DATA_WIDTH-1:0] w_q1;

    // r_en_d resets high so an enable held through reset does not count as a rise.
    assign w_start     = enable && !r_en_d;
    assign w_tick      = r_run && (r_rate_cnt == r_cfg_rate);
    assign w_two_ch    = (NUM_CHANNELS == 2) && !r_cfg_r1;
    assign w_lfsr_step = {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};

    // Last played table index: 0 -> one entry, anything >= DEPTH -> whole table.
    always_comb begin
        w_len_last = pat_len[AW-1:0] - AW'(1);
        if (pat_len[AW]) begin
            w_len_last = '1;
        end else if (pat_len[AW-1:0] == '0) begin
            w_len_last = '0;
        end
    end

    always_comb begin
        w_i1   = '0;
        w_q1   = '0;
        w_wrap = 1'b0;
        case (r_cfg_mode)
            MODE_TABLE: begin
                {w_i1, w_q1} = r_tab[r_index];
                w_wrap       = (r_index == r_last_idx);
            end
            MODE_RAMP: begin
                w_i1 = r_ramp;
                w_q1 = ~r_ramp;
            end
            MODE_PRBS: begin
                w_i1 = w_lfsr_step[DATA_WIDTH-1:0];
                w_q1 = ~w_lfsr_step[DATA_WIDTH-1:0];
            end
            default: begin
                w_i1 = '0;
                w_q1 = '0;
            end
        endcase
    end

    // Table reads in the sample path see the pre-write contents on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PATTERN_DEPTH; k++) begin
                r_tab[k] <= '0;
            end
            r_tab[0] <= {L_I0, L_Q0};
            r_tab[1] <= {L_I1, L_Q1};
        end else if (pat_wr) begin
            r_tab[pat_addr] <= pat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_d     <= 1'b1;
            r_run      <= 1'b0;
            r_cfg_mode <= MODE_ZERO;
            r_cfg_r1   <= 1'b1;
            r_cfg_rate <= '0;
            r_last_idx <= '0;
            r_rate_cnt <= '0;
            r_index    <= '0;
            r_ramp     <= '0;
            r_lfsr     <= LFSR_SEED;
            r_valid    <= 1'b0;
            r_wrap     <= 1'b0;
            r_i1       <= '0;
            r_q1       <= '0;
            r_i2       <= '0;
            r_q2       <= '0;
            r_count    <= '0;
        end else begin
            r_en_d <= enable;
            if (!enable) begin
                r_run      <= 1'b0;
                r_valid    <= 1'b0;
                r_wrap     <= 1'b0;
                r_rate_cnt <= '0;
                r_index    <= '0;
                r_ramp     <= '0;
                r_lfsr     <= LFSR_SEED;
            end else if (w_start) begin
                r_run      <= 1'b1;
                r_cfg_mode <= mode_e'(mode);
                r_cfg_r1   <= (NUM_CHANNELS == 1) ? 1'b1 : r1_mode;
                r_cfg_rate <= rate_div;
                r_last_idx <= w_len_last;
                r_rate_cnt <= '0;
                r_valid    <= 1'b0;
                r_wrap     <= 1'b0;
                r_count    <= '0;
            end else if (r_run) begin
                r_valid <= w_tick;
                r_wrap  <= w_tick && w_wrap;
                if (w_tick) begin
                    r_rate_cnt <= '0;
                    r_i1       <= w_i1;
                    r_q1       <= w_q1;
                    r_i2       <= w_two_ch ? ~w_i1 : '0;
                    r_q2       <= w_two_ch ? ~w_q1 : '0;
                    if (r_count != 32'hFFFF_FFFF) begin
                        r_count <= r_count + 32'd1;
                    end
                    if (r_cfg_mode == MODE_TABLE) begin
                        r_index <= w_wrap ? '0 : r_index + AW'(1);
                    end
                    if (r_cfg_mode == MODE_RAMP) begin
                        r_ramp <= r_ramp + DATA_WIDTH'(1);
                    end
                    if (r_cfg_mode == MODE_PRBS) begin
                        r_lfsr <= w_lfsr_step;
                    end
                end else begin
                    r_rate_cnt <= r_rate_cnt + 4'd1;
                end
            end
        end
    end

    assign dac_valid    = r_valid;
    assign dac_data_i1  = r_i1;
    assign dac_data_q1  = r_q1;
    assign dac_data_i2  = r_i2;
    assign dac_data_q2  = r_q2;
    assign dac_r1_mode  = r_cfg_r1;
    assign pat_wrap     = r_wrap;
    assign sample_count = r_count;

endmodule

// File: tb/tb_axi_ad9364_dac_tpg.sv
// Self-checking bench for axi_ad9364_dac_tpg: expected samples are queued at stimulus time
// and popped against each dac_valid.
module tb_axi_ad9364_dac_tpg;

    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TMO   = 40;

    typedef struct packed {
        logic [DW-1:0] i1;
        logic [DW-1:0] q1;
        logic [DW-1:0] i2;
        logic [DW-1:0] q2;
        logic          wrap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    mode;
    logic          r1_mode;
    logic [3:0]    rate_div;
    logic [AW:0]   pat_len;
    logic          pat_wr;
    logic [AW-1:0] pat_addr;
    logic [2*DW-1:0] pat_wdata;
    logic          dac_valid;
    logic [DW-1:0] dac_data_i1;
    logic [DW-1:0] dac_data_q1;
    logic [DW-1:0] dac_data_i2;
    logic [DW-1:0] dac_data_q2;
    logic          dac_r1_mode;
    logic          pat_wrap;
    logic [31:0]   sample_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [2*DW-1:0] tb_tab [DEPTH];

    always #5 clk = ~clk;

    axi_ad9364_dac_tpg dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .r1_mode      (r1_mode),
        .rate_div     (rate_div),
        .pat_len      (pat_len),
        .pat_wr       (pat_wr),
        .pat_addr     (pat_addr),
        .pat_wdata    (pat_wdata),
        .dac_valid    (dac_valid),
        .dac_data_i1  (dac_data_i1),
        .dac_data_q1  (dac_data_q1),
        .dac_data_i2  (dac_data_i2),
        .dac_data_q2  (dac_data_q2),
        .dac_r1_mode  (dac_r1_mode),
        .pat_wrap     (pat_wrap),
        .sample_count (sample_count)
    );

    function automatic exp_t mk(input logic [DW-1:0] i1, input logic [DW-1:0] q1,
                                input logic two, input logic wrap);
        exp_t e;
        e.i1   = i1;
        e.q1   = q1;
        e.i2   = two ? ~i1 : '0;
        e.q2   = two ? ~q1 : '0;
        e.wrap = wrap;
        return e;
    endfunction

    function automatic int last_of(input logic [AW:0] len);
        if (len == 0) return 0;
        if (int'(len) > DEPTH) return DEPTH - 1;
        return int'(len) - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < TMO) begin
            tick();
            cyc++;
            if (dac_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [3:0] r, input logic [AW:0] l, input logic o);
        mode     = m;
        rate_div = r;
        pat_len  = l;
        r1_mode  = o;
        enable   = 1'b1;
    endtask

    task automatic stop_run();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic push_table(input int n, input logic [AW:0] len, input logic two);
        int idx = 0;
        int last = last_of(len);
        for (int k = 0; k < n; k++) begin
            sb.push_back(mk(tb_tab[idx][2*DW-1:DW], tb_tab[idx][DW-1:0], two, idx == last));
            idx = (idx == last) ? 0 : idx + 1;
        end
    endtask

    task automatic write_tab(input logic [AW-1:0] a, input logic [DW-1:0] i, input logic [DW-1:0] q);
        pat_wr    = 1'b1;
        pat_addr  = a;
        pat_wdata = {i, q};
        tick();
        pat_wr    = 1'b0;
        tb_tab[a] = {i, q};
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'd0; r1_mode = 1'b0; rate_div = 4'd0;
        pat_len = '0; pat_wr = 1'b0; pat_addr = '0; pat_wdata = '0;
        tick();
        tick();
        checks++;
        if ({dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap, dac_r1_mode, sample_count}
            !== {1'b0, {4*DW{1'b0}}, 1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b i1=%h q1=%h i2=%h q2=%h wrap=%b r1=%b cnt=%0d want all 0, r1=1",
                     dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap, dac_r1_mode, sample_count);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (dac_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b want 0", dac_valid);
        end
    endtask

    task automatic test_legacy();
        bit got; int cyc; exp_t e, obs;
        start_run(2'd1, 4'd1, 3'd2, 1'b0);
        push_table(6, 3'd2, 1'b1);
        for (int k = 0; k < 6; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL legacy_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL legacy_data: sample %0d got %h want %h", k, obs, e); end
            checks++;
            if (cyc != ((k == 0) ? 3 : 2)) begin errors++; $display("FAIL legacy_pacing: sample %0d got %0d want %0d", k, cyc, (k == 0) ? 3 : 2); end
            checks++;
            if (sample_count !== 32'(k + 1)) begin errors++; $display("FAIL legacy_count: got %0d want %0d", sample_count, k + 1); end
        end
        sb.delete();
        stop_run();
    endtask

    task automatic test_table_write();
        bit got; int cyc; exp_t e, obs;
        write_tab(2'd0, 12'd1, 12'd2);
        write_tab(2'd1, 12'd3, 12'd4);
        write_tab(2'd2, 12'd5, 12'd6);
        write_tab(2'd3, 12'd7, 12'd8);
        start_run(2'd1, 4'd0, 3'd3, 1'b0);
        push_table(7, 3'd3, 1'b1);
        for (int k = 0; k < 7; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL table_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL table_data: sample %0d got %h want %h", k, obs, e); end
            checks++;
            if (cyc != ((k == 0) ? 2 : 1)) begin errors++; $display("FAIL table_pacing: sample %0d got %0d want %0d", k, cyc, (k == 0) ? 2 : 1); end
        end
        sb.delete();
        stop_run();
    endtask

    task automatic test_clamp_r1();
        bit got; int cyc; exp_t e, obs;
        start_run(2'd1, 4'd0, 3'd7, 1'b1);
        push_table(9, 3'd7, 1'b0);
        for (int k = 0; k < 9; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL clamp_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL clamp_data: sample %0d got %h want %h", k, obs, e); end
        end
        checks++;
        if (dac_r1_mode !== 1'b1) begin errors++; $display("FAIL clamp_r1_mode: got %b want 1", dac_r1_mode); end
        sb.delete();
        stop_run();
    endtask

    task automatic test_zero();
        bit got; int cyc; exp_t e, obs;
        start_run(2'd0, 4'd1, 3'd2, 1'b0);
        for (int k = 0; k < 3; k++) sb.push_back(mk('0, '0, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL zero_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL zero_data: sample %0d got %h want %h", k, obs, e); end
        end
        sb.delete();
        stop_run();
    endtask

    task automatic test_ramp();
        bit got; int cyc; exp_t e, obs;
        logic [DW-1:0] v;
        start_run(2'd2, 4'd0, 3'd0, 1'b0);
        for (int k = 0; k < 4100; k++) begin
            v = DW'(k);
            sb.push_back(mk(v, ~v, 1'b1, 1'b0));
        end
        for (int k = 0; k < 4100; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL ramp_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL ramp_data: sample %0d got %h want %h", k, obs, e); end
            checks++;
            if (cyc != ((k == 0) ? 2 : 1)) begin errors++; $display("FAIL ramp_pacing: sample %0d got %0d want %0d", k, cyc, (k == 0) ? 2 : 1); end
        end
        checks++;
        if (dac_r1_mode !== 1'b0) begin errors++; $display("FAIL ramp_r1_mode: got %b want 0", dac_r1_mode); end
        sb.delete();
        stop_run();
    endtask

    task automatic test_prbs();
        bit got; int cyc; exp_t e, obs;
        logic [14:0] lfsr = 15'h7FFF;
        start_run(2'd3, 4'd0, 3'd0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            sb.push_back(mk(lfsr[DW-1:0], ~lfsr[DW-1:0], 1'b1, 1'b0));
        end
        for (int k = 0; k < 1000; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL prbs_timeout: sample %0d got no valid want valid", k); break; end
            if (k == 0) begin
                checks++;
                if (dac_data_i1 !== 12'hFFE) begin errors++; $display("FAIL prbs_first: got %h want ffe", dac_data_i1); end
            end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL prbs_data: sample %0d got %h want %h", k, obs, e); end
        end
        sb.delete();
        stop_run();
    endtask

    task automatic test_rate_change();
        bit got; int cyc; exp_t e, obs;
        logic [DW-1:0] v;
        start_run(2'd2, 4'd0, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            v = DW'(k);
            sb.push_back(mk(v, ~v, 1'b1, 1'b0));
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                rate_div = 4'd3; mode = 2'd0; r1_mode = 1'b1;
            end
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL hold_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL hold_data: sample %0d got %h want %h", k, obs, e); end
            checks++;
            if (cyc != ((k == 0) ? 2 : 1)) begin errors++; $display("FAIL hold_pacing: sample %0d got %0d want %0d", k, cyc, (k == 0) ? 2 : 1); end
        end
        sb.delete();
        stop_run();
        checks++;
        if ({dac_valid, sample_count} !== {1'b0, 32'd8}) begin
            errors++; $display("FAIL idle_hold: got v=%b cnt=%0d want v=0 cnt=8", dac_valid, sample_count);
        end
        start_run(2'd2, 4'd3, 3'd0, 1'b0);
        tick();
        checks++;
        if ({dac_valid, sample_count} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL restart_clear: got v=%b cnt=%0d want v=0 cnt=0", dac_valid, sample_count);
        end
        for (int k = 0; k < 3; k++) begin
            v = DW'(k);
            sb.push_back(mk(v, ~v, 1'b1, 1'b0));
        end
        for (int k = 0; k < 3; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL rate4_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rate4_data: sample %0d got %h want %h", k, obs, e); end
            checks++;
            if (cyc != 4) begin errors++; $display("FAIL rate4_pacing: sample %0d got %0d want 4", k, cyc); end
            checks++;
            if (sample_count !== 32'(k + 1)) begin errors++; $display("FAIL rate4_count: got %0d want %0d", sample_count, k + 1); end
        end
        sb.delete();
        stop_run();
    endtask

    task automatic test_rst_mid();
        bit got; int cyc; int seen; exp_t e, obs;
        start_run(2'd1, 4'd0, 3'd3, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({dac_valid, dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap, dac_r1_mode, sample_count}
            !== {1'b0, {4*DW{1'b0}}, 1'b0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL rst_mid_state: got v=%b i1=%h q1=%h wrap=%b r1=%b cnt=%0d want all 0, r1=1",
                     dac_valid, dac_data_i1, dac_data_q1, pat_wrap, dac_r1_mode, sample_count);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dac_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_no_restart: got %0d valids want 0", seen); end
        tb_tab[0] = {12'o2064, 12'o1753};
        tb_tab[1] = {12'o4402, 12'o1337};
        tb_tab[2] = '0;
        tb_tab[3] = '0;
        stop_run();
        start_run(2'd1, 4'd0, 3'd0, 1'b0);
        push_table(4, 3'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_valid(got, cyc);
            checks++;
            if (!got) begin errors++; $display("FAIL len0_timeout: sample %0d got no valid want valid", k); break; end
            e = sb.pop_front();
            obs = {dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2, pat_wrap};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL len0_data: sample %0d got %h want %h", k, obs, e); end
        end
        sb.delete();
        stop_run();
    endtask

    initial begin
        tb_tab[0] = {12'o2064, 12'o1753};
        tb_tab[1] = {12'o4402, 12'o1337};
        tb_tab[2] = '0;
        tb_tab[3] = '0;
        test_reset();
        test_legacy();
        test_table_write();
        test_clamp_r1();
        test_zero();
        test_ramp();
        test_prbs();
        test_rate_change();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
